// File: rtl/progress_watchdog.sv
// progress_watchdog: enforces no-progress timeout and total cycle budget, parking in EXPIRED with sticky flags.
// Optional WATCHDOG_SNAPSHOT_EN adds expire_cycle and last_progress_cycle snapshot outputs.
module progress_watchdog #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] max_cycles,
    input  logic             enable,
    input  logic             progress,
    input  logic             clear,
    output logic [WIDTH-1:0] idle_count,
    output logic [WIDTH-1:0] cycle_count,
    output logic             timeout,
    output logic             overrun,
    output logic             expired,
`ifdef WATCHDOG_SNAPSHOT_EN
    output logic [WIDTH-1:0] expire_cycle,
    output logic [WIDTH-1:0] last_progress_cycle,
`endif
    output logic [1:0]       cause
);
    typedef enum logic [1:0] {IDLE, ARMED, EXPIRED} state_t;
    localparam logic [WIDTH:0] ONE = 1;
    state_t state;
    logic [WIDTH:0] idle_p1, cyc_p1;
    logic [WIDTH-1:0] idle_inc, cyc_inc;
    logic hit_to, hit_ov;
    // One extra bit keeps the carry so counters saturate and limit = all-ones stays reachable
    assign idle_p1  = {1'b0, idle_count} + ONE;
    assign cyc_p1   = {1'b0, cycle_count} + ONE;
    assign cyc_inc  = cyc_p1[WIDTH] ? cycle_count : cyc_p1[WIDTH-1:0];
    assign idle_inc = progress ? '0 : idle_p1[WIDTH] ? idle_count : idle_p1[WIDTH-1:0];
    assign hit_to   = |limit && !progress && idle_p1 >= {1'b0, limit};
    assign hit_ov   = |max_cycles && cyc_p1 >= {1'b0, max_cycles};
    always_ff @(posedge clock or posedge reset) begin
        if (reset || clear) begin
            state       <= IDLE;
            idle_count  <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
            expired     <= 1'b0;
            cause       <= 2'b00;
`ifdef WATCHDOG_SNAPSHOT_EN
            expire_cycle        <= '0;
            last_progress_cycle <= '0;
`endif
        end else if (state == IDLE) begin
            if (enable && (|limit || |max_cycles))
                state <= ARMED;
        end else if (state == ARMED) begin
            if (!enable) begin
                state <= IDLE;
            end else begin
                cycle_count <= cyc_inc;
                idle_count  <= idle_inc;
`ifdef WATCHDOG_SNAPSHOT_EN
                if (progress)
                    last_progress_cycle <= cyc_inc;
                if (hit_to || hit_ov)
                    expire_cycle <= cyc_inc;
`endif
                if (hit_to || hit_ov) begin
                    state   <= EXPIRED;
                    expired <= 1'b1;
                    timeout <= hit_to;
                    overrun <= hit_ov;
                    cause   <= {hit_ov, hit_to};
                end
            end
        end
    end
endmodule

// File: doc/progress_watchdog.md
Name: progress_watchdog

Overview:
- Downstream consumer of the simulation plusarg value reader.
- Takes the run-time limits that reader produces, e.g. the no-progress timeout and the max-cycles budget, and enforces them.
- Counts total cycles and consecutive cycles without a forward-progress pulse. Raises sticky timeout/overrun flags and parks in an EXPIRED state.
- Fully synthesizable; the harness or testbench decides what to do with the flags.

Parameters:
- WIDTH, 32, width of limit inputs and both counters.

Ports:
- clock  input  1  single clock domain.
- reset  input  1  asynchronous, active-high reset.
- limit  input  WIDTH  no-progress limit, from plusarg reader; 0 disables the timeout check.
- max_cycles  input  WIDTH  absolute cycle budget, from plusarg reader; 0 disables the overrun check.
- enable  input  1  count only while high.
- progress  input  1  forward-progress pulse; one per cycle counts once.
- clear  input  1  synchronous clear of state, counters and flags.
- idle_count  output  WIDTH  consecutive non-progress cycles while ARMED.
- cycle_count  output  WIDTH  total ARMED cycles.
- timeout  output  1  sticky, no-progress limit hit.
- overrun  output  1  sticky, cycle budget hit.
- expired  output  1  high while in EXPIRED.
- cause  output  2  bit0 = timeout, bit1 = overrun; captured at expiry.

Behaviour:
- Reset (async assert, released synchronously by the environment): state IDLE, all counters 0, timeout/overrun/expired 0, cause 2'b00.
- States: IDLE, ARMED, EXPIRED. Encoding is free; expired = (state==EXPIRED), registered, no combinational path from inputs.
- Priority each cycle: clear > expiry > enable/progress.
- clear=1, any state: next state IDLE, both counters 0, flags 0, cause 0.
- IDLE -> ARMED when enable=1 and (limit!=0 or max_cycles!=0). No counting in the transition cycle. Counters hold their values in IDLE.
- ARMED, enable=0 -> IDLE. Counters hold (pause, not reset). A later re-arm resumes from the held values.
- ARMED, enable=1, per cycle:
  - cycle_count += 1.
  - idle_count <= progress ? 0 : idle_count+1.
- Timeout condition: limit!=0 and progress=0 and (idle_count+1) >= limit.
  - Comparison is >=, so lowering limit mid-run below idle_count expires on the next counted cycle.
  - progress in the same cycle suppresses timeout.
- Overrun condition: max_cycles!=0 and (cycle_count+1) >= max_cycles.
- Either condition true: next state EXPIRED. Set the matching sticky flag(s) and cause. Both conditions in the same cycle give cause=2'b11. Counters take their incremented values on that edge.
- Result: limit=N expires exactly N consecutive non-progress counted cycles after the last progress or arm. max_cycles=M expires on the M-th counted cycle.
- EXPIRED: counters frozen; progress, enable and limit changes ignored; flags held. Exit only via clear or reset.
- Arithmetic: counters saturate at all-ones, no wrap. The +1 compares are done at WIDTH+1 bits so limit = all-ones is reachable.
- Reset asserted mid-run (any state): immediate return to reset values, no clock needed.

Optional Feature:
- Macro: WATCHDOG_SNAPSHOT_EN.
- Defined: extra output expire_cycle (WIDTH).
  - Loaded with the post-increment cycle_count on the edge entering EXPIRED.
  - Held until clear or reset, both of which zero it.
  - Also adds a registered output last_progress_cycle (WIDTH): the cycle_count value at the most recent counted progress pulse; 0 after reset or clear.
- Not defined: neither port exists; no extra registers; all other behaviour identical.

Test Plan:
- Single timeout: limit=5, max_cycles=0, enable=1, no progress -> expired rises after 5 counted cycles; timeout=1, cause=01, idle_count=5, cycle_count=5.
- Progress keeps it alive: limit=4, progress pulse every 3rd cycle for 100 cycles -> never expires; idle_count peaks at 2. Then stop pulses -> expiry 4 cycles after the last pulse.
- Simultaneous causes: limit=10, max_cycles=10, no progress -> expires on cycle 10 with cause=11, timeout=1, overrun=1.
- Pause and resume: limit=8; after 3 counted cycles drop enable for 20 cycles, then re-raise -> counters hold at 3 during the pause; expiry 5 counted cycles after re-arm; cycle_count=8.
- Clear and reset mid-operation: in EXPIRED assert clear 1 cycle -> IDLE, all outputs 0, re-arms next cycle. Async reset pulse mid-ARMED between edges -> outputs 0 immediately.
- Disabled and edge cases: limit=0, max_cycles=0, enable=1 -> stays IDLE forever. With WIDTH=4, max_cycles=4'hF -> overrun at cycle 15; limit lowered from 10 to 2 while idle_count=6 -> expires the next counted cycle.
